// File: rtl/regslv_apb_bridge_pkg.sv
// rtl/regslv_apb_bridge_pkg.sv - shared types and helpers for the native-to-APB leaf bridge
package regslv_apb_bridge_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/regslv_apb_bridge_timeout_cnt.sv
// rtl/regslv_apb_bridge_timeout_cnt.sv - ACCESS-phase watchdog counter with expire pulse
module regslv_apb_bridge_timeout_cnt #(
    parameter int LIMIT = 256,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] cnt;

    assign expire = en && (cnt == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/regslv_apb_bridge.sv
// rtl/regslv_apb_bridge.sv - reg_native_if to APB initiator bridge
// Optional ACCESS-phase timeout enabled by REGSLV_APB_BRIDGE_TIMEOUT_EN.
module regslv_apb_bridge
    import regslv_apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  fsm_clk,
    input  logic                  fsm_rstn,
    input  logic                  req_vld,
    output logic                  ack_vld,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  err_vld,
    input  logic                  global_sync_reset_in,
    output logic                  global_sync_reset_out,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    state_t                  state, state_nxt;
    logic                    psel_nxt, penable_nxt, pwrite_nxt, ack_nxt, err_nxt;
    logic [ADDR_WIDTH-1:0]   paddr_nxt;
    logic [DATA_WIDTH-1:0]   pwdata_nxt, rd_data_nxt;
    logic                    timeout_expire;

`ifdef REGSLV_APB_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

    regslv_apb_bridge_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_timeout_cnt (
        .clk    (fsm_clk),
        .rst_n  (fsm_rstn),
        .load   (state == ST_SETUP),
        .en     (state == ST_ACCESS),
        .expire (timeout_expire)
    );
`else
    assign timeout_expire = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        psel_nxt    = PSEL;
        penable_nxt = PENABLE;
        pwrite_nxt  = PWRITE;
        paddr_nxt   = PADDR;
        pwdata_nxt  = PWDATA;
        rd_data_nxt = rd_data;
        err_nxt     = err_vld;
        ack_nxt     = 1'b0;

        // response fields are only meaningful alongside ack_vld
        if (ack_vld) begin
            rd_data_nxt = '0;
            err_nxt     = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (req_vld) begin
                    if (wr_en ^ rd_en) begin
                        paddr_nxt  = addr;
                        pwdata_nxt = wr_data;
                        pwrite_nxt = wr_en;
                        psel_nxt   = 1'b1;
                        state_nxt  = ST_SETUP;
                    end else begin
                        rd_data_nxt = '0;
                        err_nxt     = 1'b1;
                        state_nxt   = ST_ACK;
                    end
                end
            end
            ST_SETUP: begin
                penable_nxt = 1'b1;
                state_nxt   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PSEL && PENABLE && PREADY) begin
                    rd_data_nxt = PWRITE ? '0 : PRDATA;
                    err_nxt     = PSLVERR;
                    psel_nxt    = 1'b0;
                    penable_nxt = 1'b0;
                    state_nxt   = ST_ACK;
                end else if (timeout_expire) begin
                    rd_data_nxt = '0;
                    err_nxt     = 1'b1;
                    psel_nxt    = 1'b0;
                    penable_nxt = 1'b0;
                    state_nxt   = ST_ACK;
                end
            end
            ST_ACK: begin
                ack_nxt   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // soft reset abandons any in-flight transfer without acknowledging it
        if (global_sync_reset_in) begin
            state_nxt   = ST_IDLE;
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
            pwrite_nxt  = 1'b0;
            paddr_nxt   = '0;
            pwdata_nxt  = '0;
            rd_data_nxt = '0;
            err_nxt     = 1'b0;
            ack_nxt     = 1'b0;
        end
    end

    always_ff @(posedge fsm_clk or negedge fsm_rstn) begin
        if (!fsm_rstn) begin
            state                 <= ST_IDLE;
            PSEL                  <= 1'b0;
            PENABLE               <= 1'b0;
            PWRITE                <= 1'b0;
            PADDR                 <= '0;
            PWDATA                <= '0;
            rd_data               <= '0;
            err_vld               <= 1'b0;
            ack_vld               <= 1'b0;
            global_sync_reset_out <= 1'b0;
        end else begin
            state                 <= state_nxt;
            PSEL                  <= psel_nxt;
            PENABLE               <= penable_nxt;
            PWRITE                <= pwrite_nxt;
            PADDR                 <= paddr_nxt;
            PWDATA                <= pwdata_nxt;
            rd_data               <= rd_data_nxt;
            err_vld               <= err_nxt;
            ack_vld               <= ack_nxt;
            global_sync_reset_out <= global_sync_reset_in;
        end
    end

    a_single_outstanding: assert property (
        @(posedge fsm_clk) disable iff (!fsm_rstn) req_vld |-> (state == ST_IDLE)
    );

endmodule

// File: tb/tb_regslv_apb_bridge.sv
// tb/tb_regslv_apb_bridge.sv - scoreboard bench for regslv_apb_bridge
module tb_regslv_apb_bridge;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          fsm_clk = 1'b0;
    logic          fsm_rstn;
    logic          req_vld, wr_en, rd_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic          ack_vld, err_vld;
    logic [DW-1:0] rd_data;
    logic          global_sync_reset_in, global_sync_reset_out;
    logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;

    regslv_apb_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .fsm_clk(fsm_clk), .fsm_rstn(fsm_rstn), .req_vld(req_vld), .ack_vld(ack_vld),
        .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .err_vld(err_vld), .global_sync_reset_in(global_sync_reset_in),
        .global_sync_reset_out(global_sync_reset_out), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 fsm_clk = ~fsm_clk;

    typedef struct { int cyc; logic [DW-1:0] rd; logic err; } ack_exp_t;
    typedef struct { int setup_cyc; logic [AW-1:0] a; logic [DW-1:0] d; logic wr; } apb_exp_t;

    ack_exp_t      ack_q[$];
    apb_exp_t      apb_q[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            tgt_waits = 0;
    logic [DW-1:0] tgt_rdata = '0;
    logic          tgt_err = 1'b0;

    initial forever begin
        @(posedge fsm_clk);
        cyc++;
    end

    // APB target: completes on the tgt_waits-th ACCESS cycle, junk elsewhere
    initial begin
        int acc;
        acc = 0;
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        forever begin
            @(posedge fsm_clk);
            #1;
            if (PSEL && PENABLE) begin
                PREADY  = (acc == tgt_waits);
                PRDATA  = PREADY ? tgt_rdata : DW'($urandom);
                PSLVERR = PREADY ? tgt_err : 1'($urandom_range(0, 1));
                acc++;
            end else begin
                acc     = 0;
                PREADY  = 1'b0;
                PSLVERR = 1'($urandom_range(0, 1));
            end
        end
    end

    // monitor: pops expectations whenever the DUT presents an APB beat or an ack
    initial forever begin
        @(negedge fsm_clk);
        if (fsm_rstn) begin
            if (PSEL) begin
                total++;
                if (apb_q.size() == 0) begin
                    bad++;
                    $display("FAIL psel_unexpected cyc=%0d got PSEL=1 want 0", cyc);
                end else if (!PENABLE) begin
                    if (cyc != apb_q[0].setup_cyc) begin
                        bad++;
                        $display("FAIL psel_cycle got %0d want %0d", cyc, apb_q[0].setup_cyc);
                    end
                end else if (PREADY) begin
                    apb_exp_t e;
                    e = apb_q.pop_front();
                    if (PADDR !== e.a || PWRITE !== e.wr || (e.wr && PWDATA !== e.d)) begin
                        bad++;
                        $display("FAIL apb_beat got a=%h w=%b d=%h want a=%h w=%b d=%h",
                                 PADDR, PWRITE, PWDATA, e.a, e.wr, e.d);
                    end
                end
            end
            if (ack_vld) begin
                total++;
                if (ack_q.size() == 0) begin
                    bad++;
                    $display("FAIL ack_unexpected cyc=%0d got ack_vld=1 want 0", cyc);
                end else begin
                    ack_exp_t e;
                    e = ack_q.pop_front();
                    if (cyc != e.cyc || rd_data !== e.rd || err_vld !== e.err) begin
                        bad++;
                        $display("FAIL ack got cyc=%0d rd=%h err=%b want cyc=%0d rd=%h err=%b",
                                 cyc, rd_data, err_vld, e.cyc, e.rd, e.err);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // caller is at posedge+1; request is presented for exactly this cycle
    task automatic issue(input bit wr, input bit rd, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int waits,
                         input logic [DW-1:0] rdat, input bit err);
        int c;
        ack_exp_t ae;
        apb_exp_t pe;
        c = cyc;
        tgt_waits = waits; tgt_rdata = rdat; tgt_err = err;
        if (wr ^ rd) begin
            pe.setup_cyc = c + 1; pe.a = a; pe.d = d; pe.wr = wr;
            apb_q.push_back(pe);
            if (waits <= TO - 1) begin
                ae.cyc = c + 4 + waits; ae.rd = wr ? '0 : rdat; ae.err = err;
                ack_q.push_back(ae);
            end else begin
`ifdef REGSLV_APB_BRIDGE_TIMEOUT_EN
                ae.cyc = c + 3 + TO; ae.rd = '0; ae.err = 1'b1;
                ack_q.push_back(ae);
`endif
            end
        end else begin
            ae.cyc = c + 2; ae.rd = '0; ae.err = 1'b1;
            ack_q.push_back(ae);
        end
        req_vld = 1'b1; wr_en = wr; rd_en = rd; addr = a; wr_data = d;
        @(posedge fsm_clk); #1;
        req_vld = 1'b0; wr_en = 1'($urandom_range(0, 1)); rd_en = 1'($urandom_range(0, 1));
        addr = {$urandom, $urandom}; wr_data = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((ack_q.size() != 0 || apb_q.size() != 0) && n < 60) begin
            @(posedge fsm_clk); #1;
            n++;
        end
        if (ack_q.size() != 0 || apb_q.size() != 0) begin
            total++; bad++;
            $display("FAIL wait_idle got pending=%0d want 0", ack_q.size() + apb_q.size());
            ack_q.delete(); apb_q.delete();
        end
        repeat ($urandom_range(0, 2)) begin
            @(posedge fsm_clk); #1;
        end
    endtask

    initial begin
        fsm_rstn = 1'b0; req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        addr = '0; wr_data = '0; global_sync_reset_in = 1'b0;
        repeat (3) @(posedge fsm_clk);
        #1;
        chk("rst_psel_pen_pwrite", {61'd0, PSEL, PENABLE, PWRITE}, 64'd0);
        chk("rst_paddr", PADDR, 64'd0);
        chk("rst_pwdata", {32'd0, PWDATA}, 64'd0);
        chk("rst_ack_err_gsr", {61'd0, ack_vld, err_vld, global_sync_reset_out}, 64'd0);
        chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
        fsm_rstn = 1'b1;
        @(posedge fsm_clk); #1;

        issue(1'b1, 1'b0, 64'h10, 32'h1234_5678, 0, 32'h0, 1'b0);
        wait_idle();
        issue(1'b0, 1'b1, 64'h20, 32'h0, 3, 32'hdead_beef, 1'b0);
        wait_idle();
        issue(1'b1, 1'b0, 64'h30, 32'hcafe_f00d, 1, 32'h5555_aaaa, 1'b1);
        wait_idle();
        issue(1'b1, 1'b1, 64'h40, 32'h1, 0, 32'h0, 1'b0);
        wait_idle();
        issue(1'b0, 1'b0, 64'h44, 32'h2, 0, 32'h0, 1'b0);
        wait_idle();
        issue(1'b0, 1'b1, 64'h48, 32'h0, TO - 1, 32'h0bad_cafe, 1'b0);
        wait_idle();

        begin
            int c0;
            c0 = cyc;
            issue(1'b0, 1'b1, 64'h50, 32'h0, 1000, 32'h0, 1'b0);
            repeat (2) begin
                @(posedge fsm_clk); #1;
            end
            chk("gsr_pre_access", {62'd0, PSEL, PENABLE}, 64'd3);
            chk("gsr_in_cycle", 64'(cyc - c0), 64'd3);
            global_sync_reset_in = 1'b1;
            @(posedge fsm_clk); #1;
            global_sync_reset_in = 1'b0;
            chk("gsr_apb_cleared", {62'd0, PSEL, PENABLE}, 64'd0);
            chk("gsr_out_high", {63'd0, global_sync_reset_out}, 64'd1);
            ack_q.delete(); apb_q.delete();
            @(posedge fsm_clk); #1;
            chk("gsr_out_low", {63'd0, global_sync_reset_out}, 64'd0);
            repeat (12) begin
                @(posedge fsm_clk); #1;
            end
            issue(1'b0, 1'b1, 64'h54, 32'h0, 2, 32'h1357_9bdf, 1'b0);
            wait_idle();
        end

`ifdef REGSLV_APB_BRIDGE_TIMEOUT_EN
        issue(1'b0, 1'b1, 64'h60, 32'h0, 1000, 32'hffff_ffff, 1'b0);
        wait_idle();
`endif

        for (int i = 0; i < 40; i++) begin
            bit wr, rd;
            int kind;
            kind = $urandom_range(0, 7);
            if (kind == 0) begin
                wr = 1'($urandom_range(0, 1)); rd = wr;
            end else begin
                wr = 1'($urandom_range(0, 1)); rd = !wr;
            end
            issue(wr, rd, {$urandom, $urandom}, $urandom, $urandom_range(0, 4),
                  $urandom, ($urandom_range(0, 3) == 0));
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/regslv_apb_bridge.md
Name: regslv_apb_bridge

Overview:
- Leaf bridge that terminates a reg_native_if downstream port of a regmst or regslv and acts as an APB initiator toward an external APB register target.
- Each native request becomes exactly one APB transfer.
- Each APB completion becomes exactly one ack_vld pulse back upstream.
- Placed as an external instance under a regslv so that third-party APB register files appear in the generated address map.

Parameters:
- ADDR_WIDTH, 64, width of native addr and PADDR.
- DATA_WIDTH, 32, width of native wr_data/rd_data and PWDATA/PRDATA.
- TIMEOUT_CYCLES, 256, ACCESS-phase cycles before a transfer is aborted (used only with the optional feature).

Ports:
- fsm_clk  in  1  single clock for the native side and APB side.
- fsm_rstn  in  1  asynchronous active-low reset.
- req_vld  in  1  native request strobe, one cycle.
- ack_vld  out  1  native completion strobe, one cycle.
- wr_en  in  1  write request, qualified by req_vld.
- rd_en  in  1  read request, qualified by req_vld.
- addr  in  ADDR_WIDTH  request address.
- wr_data  in  DATA_WIDTH  write data.
- rd_data  out  DATA_WIDTH  read data, valid with ack_vld.
- err_vld  out  1  error flag, valid only with ack_vld.
- global_sync_reset_in  in  1  synchronous soft reset from upstream.
- global_sync_reset_out  out  1  registered copy of global_sync_reset_in.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Reset (fsm_rstn low, asynchronous): FSM in IDLE; all outputs 0, including rd_data and global_sync_reset_out.
- FSM states: IDLE, SETUP, ACCESS, ACK. All outputs are registered.
- IDLE:
  - req_vld with exactly one of wr_en/rd_en: capture addr, wr_data and direction into PADDR/PWDATA/PWRITE, set PSEL=1, go to SETUP.
  - req_vld with both or neither of wr_en/rd_en: go to ACK with rd_data=0 and err_vld=1; no APB transfer is issued.
- SETUP: PENABLE=1 on the next edge, go to ACCESS. Lasts exactly one cycle.
- ACCESS: hold PSEL=1, PENABLE=1 and all APB outputs stable until PREADY=1.
- On the PREADY=1 edge:
  - Register rd_data = PRDATA for reads, 0 for writes.
  - Register err_vld = PSLVERR.
  - Clear PSEL and PENABLE; go to ACK.
- ACK: ack_vld=1 for exactly one cycle, then return to IDLE. rd_data and err_vld return to 0 after the ACK cycle.
- Latency with a zero-wait APB target: req_vld in cycle 0, PSEL in cycle 1, PENABLE in cycle 2, ack_vld in cycle 4. Each target wait state adds one cycle.
- req_vld while not in IDLE is ignored; no queuing. Upstream guarantees at most one outstanding request. A simulation-only assertion flags a violation.
- global_sync_reset_in=1 in any state, on the next edge:
  - FSM returns to IDLE and all APB outputs clear.
  - An in-flight transfer is abandoned with no ack_vld.
  - global_sync_reset_out follows with one cycle of delay.
- PSLVERR is sampled only when PSEL, PENABLE and PREADY are all high.

Optional Feature:
- Macro: REGSLV_APB_BRIDGE_TIMEOUT_EN.
- When defined:
  - An ACCESS-cycle counter starts at 0 on entry to ACCESS.
  - When the counter reaches TIMEOUT_CYCLES-1 without PREADY, the bridge drops PSEL/PENABLE and goes to ACK with rd_data=0 and err_vld=1.
  - If PREADY arrives on the same cycle as the limit, the normal completion wins.
- When undefined: no counter; the bridge waits in ACCESS indefinitely.

Decomposition:
- Package regslv_apb_bridge_pkg holds:
  - the state enum typedef (IDLE/SETUP/ACCESS/ACK);
  - the 2-bit state-width localparam;
  - the timeout counter width function clog2(TIMEOUT_CYCLES).
- One sub-module, regslv_apb_bridge_timeout_cnt:
  - a load/enable counter with an expire pulse;
  - instantiated only under the macro.

Test Plan:
- Zero-wait write: req addr=0x10, wr_data=0x12345678 -> PSEL at cycle 1, PENABLE at cycle 2, PWDATA=0x12345678, ack_vld at cycle 4, err_vld=0.
- Read with 3 wait states, PRDATA=0xdeadbeef -> ack_vld at cycle 7, rd_data=0xdeadbeef.
- Write with PSLVERR=1 at completion -> ack_vld together with err_vld=1, rd_data=0.
- req_vld with wr_en=rd_en=1 -> no PSEL; ack_vld two cycles later with err_vld=1.
- global_sync_reset_in pulsed during ACCESS -> PSEL/PENABLE cleared next cycle, no ack_vld, global_sync_reset_out high one cycle later; the following read completes normally.
- Macro defined, TIMEOUT_CYCLES=8, PREADY held 0 -> PSEL drops after 8 ACCESS cycles; ack_vld with rd_data=0 and err_vld=1.
